lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/riscv_pkg.sv | 67 ++++++
 rtl/lsu_load_align.sv | 38 +++
 rtl/lsu_stage.sv | 124 ++++++++++++
 tb/tb_lsu_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU FSM encoding,
// byte-lane strobe constants and small decode helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } lsu_state_t;

    function automatic logic funct3_legal(input logic load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (load)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return ok;
    endfunction

    // Bit 1:0 of funct3 give the access size for both signed and unsigned forms.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        s = STRB_NONE;
        case (f3)
            F3_B:    s = STRB_BYTE << a;
            F3_H:    s = STRB_HALF << {a[1], 1'b0};
            F3_W:    s = STRB_WORD;
            default: s = STRB_NONE;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends
// it according to the load funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        val = 32'd0;
        case (funct3)
            F3_B:    val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    val = {{16{half_sel[15]}}, half_sel};
            F3_W:    val = rdata;
            F3_BU:   val = {24'd0, byte_sel};
            F3_HU:   val = {16'd0, half_sel};
            default: val = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// RV32I load/store stage: one outstanding access, IDLE -> ACCESS -> WB FSM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with a misalign pulse.
module lsu_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_w_val,
    output logic              misalign
);

    lsu_state_t state, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_reg;
    logic              load_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       load_val;
    logic              handshake;
    logic              req_ok;

    assign handshake = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap_mis;
    logic misalign_reg;

    assign trap_mis = funct3_legal(req_load, req_funct3) &&
                      addr_misaligned(req_funct3, req_addr[1:0]);
    assign req_ok   = funct3_legal(req_load, req_funct3) && !trap_mis;
    assign misalign = misalign_reg;

    always_ff @(posedge clock) begin
        if (reset)
            misalign_reg <= 1'b0;
        else
            misalign_reg <= handshake && trap_mis;
    end
`else
    assign req_ok   = funct3_legal(req_load, req_funct3);
    assign misalign = 1'b0;
`endif

    // Rejected requests are consumed in IDLE and never reach ACCESS.
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (handshake && req_ok) state_next = ST_ACCESS;
            ST_ACCESS: if (dmem_ack) state_next = load_reg ? ST_WB : ST_IDLE;
            ST_WB:     state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg   <= '0;
            funct3_reg <= 3'd0;
            rd_reg     <= 5'd0;
            load_reg   <= 1'b0;
            wdata_reg  <= 32'd0;
            wstrb_reg  <= STRB_NONE;
            rdata_reg  <= 32'd0;
        end else begin
            if (handshake && req_ok) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                rd_reg     <= req_rd;
                load_reg   <= req_load;
                wdata_reg  <= req_load ? 32'd0 : store_lanes(req_funct3, req_wdata);
                wstrb_reg  <= req_load ? STRB_NONE : store_strobe(req_funct3, req_addr[1:0]);
            end
            if (state == ST_ACCESS && dmem_ack && load_reg)
                rdata_reg <= dmem_rdata;
        end
    end

    lsu_load_align u_align (
        .rdata  (rdata_reg),
        .addr   (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .val    (load_val)
    );

    // The register file writes every cycle, so writeback fields are zero outside WB.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        dmem_req   = (state == ST_ACCESS);
        dmem_we    = (state == ST_ACCESS) && !load_reg;
        dmem_wstrb = dmem_we ? wstrb_reg : STRB_NONE;
        dmem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
        dmem_wdata = wdata_reg;
        wb_rd_addr = (state == ST_WB) ? rd_reg : 5'd0;
        wb_w_val   = (state == ST_WB) ? load_val : 32'd0;
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_lsu_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_w_val;
    logic        misalign;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    lsu_stage #(.ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_rd_addr (wb_rd_addr),
        .wb_w_val   (wb_w_val),
        .misalign   (misalign)
    );

    // Outputs are purely state-based, so sampling 1 ns after the edge is safe.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_load   = load;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_compared++; if (req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_ready: got %0h exp 1", req_ready); end
        n_compared++; if ({dmem_req, dmem_we, misalign} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL rst_ctrl: got %b exp 000", {dmem_req, dmem_we, misalign}); end
        n_compared++; if ({dmem_addr, dmem_wdata, dmem_wstrb} !== 68'd0) begin n_mismatched++; $display("[TB] FAIL rst_dmem: got %h/%h/%b exp 0", dmem_addr, dmem_wdata, dmem_wstrb); end
        n_compared++; if ({wb_rd_addr, wb_w_val} !== 37'd0) begin n_mismatched++; $display("[TB] FAIL rst_wb: got %0d/%h exp 0", wb_rd_addr, wb_w_val); end
        reset = 1'b0;
        tick();
        n_compared++; if (req_ready !== 1'b1 || dmem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_release: got ready=%0h req=%0h exp 1/0", req_ready, dmem_req); end
    endtask

    task automatic test_lw_wait();
        issue(1'b1, 3'd2, 32'h0000_0100, 32'd0, 5'd5);
        for (int i = 0; i < 3; i++) begin
            n_compared++; if (dmem_req !== 1'b1 || req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lw_wait%0d: got req=%0h ready=%0h exp 1/0", i, dmem_req, req_ready); end
            n_compared++; if (wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0) begin n_mismatched++; $display("[TB] FAIL lw_wb_idle%0d: got %0d/%h exp 0/0", i, wb_rd_addr, wb_w_val); end
            tick();
        end
        n_compared++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL lw_bus: got %h we=%0h strb=%b exp 100/0/0000", dmem_addr, dmem_we, dmem_wstrb); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        n_compared++; if (wb_rd_addr !== 5'd5 || wb_w_val !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL lw_wb: got %0d/%h exp 5/deadbeef", wb_rd_addr, wb_w_val); end
        n_compared++; if (req_ready !== 1'b0 || dmem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lw_wb_state: got ready=%0h req=%0h exp 0/0", req_ready, dmem_req); end
        tick();
        n_compared++; if (wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lw_after: got %0d/%h ready=%0h exp 0/0/1", wb_rd_addr, wb_w_val, req_ready); end
    endtask

    // Ack is raised in the very first ACCESS cycle to exercise the minimum latency.
    task automatic test_load_ext();
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, f3s[i], adrs[i], 32'd0, 5'd7);
            dmem_ack   = 1'b1;
            dmem_rdata = 32'h80FF_1234;
            n_compared++; if (dmem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ext%0d_req: got %0h exp 1", i, dmem_req); end
            tick();
            dmem_ack = 1'b0;
            n_compared++; if (wb_rd_addr !== 5'd7 || wb_w_val !== exps[i]) begin n_mismatched++; $display("[TB] FAIL ext%0d_wb: got %0d/%h exp 7/%h", i, wb_rd_addr, wb_w_val, exps[i]); end
            n_compared++; if (req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ext%0d_busy: got %0h exp 0", i, req_ready); end
            tick();
            n_compared++; if (req_ready !== 1'b1 || wb_rd_addr !== 5'd0) begin n_mismatched++; $display("[TB] FAIL ext%0d_ready: got %0h/%0d exp 1/0", i, req_ready, wb_rd_addr); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s  [3] = '{3'd1, 3'd0, 3'd2};
        logic [31:0] adrs [3] = '{32'h102, 32'h201, 32'h30C};
        logic [31:0] dats [3] = '{32'h0000_ABCD, 32'h1234_56EF, 32'hCAFE_F00D};
        logic [31:0] eadr [3] = '{32'h100, 32'h200, 32'h30C};
        logic [31:0] ewd  [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hCAFE_F00D};
        logic [3:0]  estb [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, f3s[i], adrs[i], dats[i], 5'd3);
            n_compared++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL st%0d_ctrl: got req=%0h we=%0h exp 1/1", i, dmem_req, dmem_we); end
            n_compared++; if (dmem_addr !== eadr[i] || dmem_wdata !== ewd[i] || dmem_wstrb !== estb[i]) begin n_mismatched++; $display("[TB] FAIL st%0d_bus: got %h/%h/%b exp %h/%h/%b", i, dmem_addr, dmem_wdata, dmem_wstrb, eadr[i], ewd[i], estb[i]); end
            tick();
            n_compared++; if (dmem_req !== 1'b1 || dmem_wdata !== ewd[i]) begin n_mismatched++; $display("[TB] FAIL st%0d_hold: got %0h/%h exp 1/%h", i, dmem_req, dmem_wdata, ewd[i]); end
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
            n_compared++; if (req_ready !== 1'b1 || dmem_req !== 1'b0 || wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0) begin n_mismatched++; $display("[TB] FAIL st%0d_done: got ready=%0h req=%0h wb=%0d/%h exp 1/0/0/0", i, req_ready, dmem_req, wb_rd_addr, wb_w_val); end
        end
    endtask

    task automatic test_stray_ack();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        tick();
        tick();
        n_compared++; if (req_ready !== 1'b1 || dmem_req !== 1'b0 || wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0) begin n_mismatched++; $display("[TB] FAIL stray_idle: got ready=%0h req=%0h wb=%0d/%h exp 1/0/0/0", req_ready, dmem_req, wb_rd_addr, wb_w_val); end
        dmem_ack = 1'b0;
    endtask

    task automatic test_illegal();
        logic        lds [3] = '{1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'd3, 3'd7, 3'd4};
        for (int i = 0; i < 3; i++) begin
            issue(lds[i], f3s[i], 32'h400, 32'h1111_2222, 5'd9);
            n_compared++; if (dmem_req !== 1'b0 || req_ready !== 1'b1 || wb_rd_addr !== 5'd0) begin n_mismatched++; $display("[TB] FAIL ill%0d: got req=%0h ready=%0h wb=%0d exp 0/1/0", i, dmem_req, req_ready, wb_rd_addr); end
            tick();
            n_compared++; if (dmem_req !== 1'b0 || wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0) begin n_mismatched++; $display("[TB] FAIL ill%0d_next: got req=%0h wb=%0d/%h exp 0/0/0", i, dmem_req, wb_rd_addr, wb_w_val); end
        end
    endtask

    task automatic test_rd_zero();
        issue(1'b1, 3'd2, 32'h200, 32'd0, 5'd0);
        n_compared++; if (dmem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd0_req: got %0h exp 1", dmem_req); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_ack = 1'b0;
        n_compared++; if (wb_rd_addr !== 5'd0 || req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd0_wb: got %0d ready=%0h exp 0/0", wb_rd_addr, req_ready); end
        tick();
        n_compared++; if (req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd0_ready: got %0h exp 1", req_ready); end
    endtask

    task automatic test_reset_mid_access();
        issue(1'b1, 3'd2, 32'h500, 32'd0, 5'd9);
        n_compared++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h500) begin n_mismatched++; $display("[TB] FAIL rma_access: got %0h/%h exp 1/500", dmem_req, dmem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_compared++; if (dmem_req !== 1'b0 || req_ready !== 1'b1 || dmem_addr !== 32'd0) begin n_mismatched++; $display("[TB] FAIL rma_abandon: got req=%0h ready=%0h addr=%h exp 0/1/0", dmem_req, req_ready, dmem_addr); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        tick();
        dmem_ack = 1'b0;
        n_compared++; if (wb_rd_addr !== 5'd0 || wb_w_val !== 32'd0 || dmem_req !== 1'b0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rma_late_ack: got wb=%0d/%h req=%0h ready=%0h exp 0/0/0/1", wb_rd_addr, wb_w_val, dmem_req, req_ready); end
        tick();
        n_compared++; if (wb_rd_addr !== 5'd0 || misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rma_quiet: got wb=%0d mis=%0h exp 0/0", wb_rd_addr, misalign); end
    endtask

    task automatic test_misalign();
        issue(1'b1, 3'd2, 32'h101, 32'd0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        n_compared++; if (misalign !== 1'b1 || dmem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_pulse: got mis=%0h req=%0h exp 1/0", misalign, dmem_req); end
        tick();
        n_compared++; if (misalign !== 1'b0 || dmem_req !== 1'b0 || wb_rd_addr !== 5'd0 || req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mis_after: got mis=%0h req=%0h wb=%0d ready=%0h exp 0/0/0/1", misalign, dmem_req, wb_rd_addr, req_ready); end
`else
        n_compared++; if (misalign !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin n_mismatched++; $display("[TB] FAIL mis_access: got mis=%0h req=%0h addr=%h exp 0/1/100", misalign, dmem_req, dmem_addr); end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1122_3344;
        tick();
        dmem_ack = 1'b0;
        n_compared++; if (wb_rd_addr !== 5'd4 || wb_w_val !== 32'h1122_3344) begin n_mismatched++; $display("[TB] FAIL mis_wb: got %0d/%h exp 4/11223344", wb_rd_addr, wb_w_val); end
        tick();
        issue(1'b1, 3'd5, 32'h103, 32'd0, 5'd6);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9876_5432;
        tick();
        dmem_ack = 1'b0;
        n_compared++; if (wb_rd_addr !== 5'd6 || wb_w_val !== 32'h0000_9876) begin n_mismatched++; $display("[TB] FAIL mis_half: got %0d/%h exp 6/00009876", wb_rd_addr, wb_w_val); end
`endif
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        test_reset();
        test_lw_wait();
        test_load_ext();
        test_store();
        test_stray_ack();
        test_illegal();
        test_rd_zero();
        test_reset_mid_access();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
